// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall controller for a five-stage in-order pipeline.
//
// This block resolves four things each cycle:
//   - memory-wait stalls, which freeze the whole front of the pipe while dmem is busy
//   - branch-redirect flushes
//   - load-use interlocks
//   - operand-forwarding selects for the ALU
//
// Stall and flush decisions are purely combinational. The only registered state is
// the FSM, the wait counter, the sticky timeout flag and the optional perf counters.
//
// Optional feature macro: PIPELINE_CTRL_PERF_EN
//   When defined, stall_count and flush_count are live wrapping counters.
//   When undefined, both are tied to zero and no counter flops exist.
module pipeline_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [4:0]       e_rs,
  input  logic [4:0]       e_rt,
  input  logic [4:0]       e_wa,
  input  logic             e_rf_we,
  input  logic             e_is_load,
  input  logic [4:0]       m_rf_wa,
  input  logic             m_rf_we,
  input  logic [4:0]       w_rf_wa,
  input  logic             w_rf_we,
  input  logic             m_branch_taken,
  input  logic             m_dmem_req,
  input  logic             dmem_ready,
  output logic             f_stall,
  output logic             d_stall,
  output logic             e_stall,
  output logic             m_stall,
  output logic             d_flush,
  output logic             e_flush,
  output logic             w_flush,
  output logic [1:0]       e_fwd_a,
  output logic [1:0]       e_fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              timeout_set;
  logic              mem_hold;
  logic              mem_wait;
  logic              load_use;

  // Raw (reset-ungated) control decisions. These feed the perf counters, which are
  // held in reset anyway, so reset never reaches a flop data path.
  logic f_stall_raw;
  logic d_stall_raw;
  logic e_stall_raw;
  logic m_stall_raw;
  logic d_flush_raw;
  logic e_flush_raw;
  logic w_flush_raw;

  // Forwarding select for one ALU operand.
  // The memory stage is younger than writeback, so its result wins.
  // Register 0 is hard-wired to zero and therefore never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       m_we,
    input logic [4:0] m_wa,
    input logic       w_we,
    input logic [4:0] w_wa
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_wa != 5'd0) && (m_wa == src)) begin
      sel = 2'b10;
    end else if (w_we && (w_wa != 5'd0) && (w_wa == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign mem_wait = m_dmem_req & ~dmem_ready;

  assign load_use = e_rf_we & e_is_load & (e_wa != 5'd0) &
                    ((e_wa == d_rs) | (e_wa == d_rt));

  // FSM state and wait counter; an asynchronous reset aborts any wait in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_timeout <= 1'b0;
    end else if (timeout_set) begin
      mem_timeout <= 1'b1;
    end
  end

  // Next-state and stall/flush decode.
  // Priority is memory wait, then branch flush, then load-use stall. Once a wait
  // ends (ready or timeout), branch and load-use are evaluated normally in that
  // same cycle.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    mem_hold     = 1'b0;
    f_stall_raw  = 1'b0;
    d_stall_raw  = 1'b0;
    e_stall_raw  = 1'b0;
    m_stall_raw  = 1'b0;
    d_flush_raw  = 1'b0;
    e_flush_raw  = 1'b0;
    w_flush_raw  = 1'b0;

    case (state)
      RUN: begin
        if (mem_wait) begin
          mem_hold     = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt >= WAIT_W'(MAX_WAIT)) begin
          timeout_set  = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          mem_hold     = 1'b1;
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (mem_hold) begin
      // Writeback receives a bubble while memory is held, so a held load is not
      // retired more than once.
      f_stall_raw = 1'b1;
      d_stall_raw = 1'b1;
      e_stall_raw = 1'b1;
      m_stall_raw = 1'b1;
      w_flush_raw = 1'b1;
    end else if (m_branch_taken) begin
      d_flush_raw = 1'b1;
      e_flush_raw = 1'b1;
    end else if (load_use) begin
      f_stall_raw = 1'b1;
      d_stall_raw = 1'b1;
      e_flush_raw = 1'b1;
    end
  end

  // All control outputs are forced low while reset is asserted, independent of the clock.
  assign f_stall = f_stall_raw & reset;
  assign d_stall = d_stall_raw & reset;
  assign e_stall = e_stall_raw & reset;
  assign m_stall = m_stall_raw & reset;
  assign d_flush = d_flush_raw & reset;
  assign e_flush = e_flush_raw & reset;
  assign w_flush = w_flush_raw & reset;

  assign e_fwd_a = reset ? fwd_sel(e_rs, m_rf_we, m_rf_wa, w_rf_we, w_rf_wa) : 2'b00;
  assign e_fwd_b = reset ? fwd_sel(e_rt, m_rf_we, m_rf_wa, w_rf_we, w_rf_wa) : 2'b00;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Performance counters; both wrap naturally modulo 2^CNT_W.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (f_stall_raw) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (d_flush_raw | e_flush_raw) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
